// File: rtl/ysyx_23060187_ifu_if.sv
// ============================================================================
// Module      : ysyx_23060187_ifu_if
// Description : Bundle of the signals around the IFU. It covers the
//               instruction-memory read port, the IFU->IDU valid/ready link,
//               the WBU next-PC return and the sticky status flags.
//               The master modport is the IFU side and the slave modport is
//               the environment side (memory, IDU and WBU).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_23060187_ifu_if;
  // instruction memory read port
  logic        ifu_mem_req;
  logic [31:0] ifu_mem_addr;
  logic        mem_ifu_rvalid;
  logic [31:0] mem_ifu_rdata;
  // IFU -> IDU link
  logic        IFU_IDU_valid;
  logic [31:0] IFU_IDU_inst;
  logic [31:0] IFU_IDU_pc;
  logic        IDU_IFU_ready;
  // WBU -> IFU next PC
  logic        WBU_IFU_valid;
  logic [31:0] WBU_IFU_npc;
  // sticky status
  logic        ifu_timeout;
  logic        ifu_misalign;

  modport master (
    output ifu_mem_req, ifu_mem_addr,
    input  mem_ifu_rvalid, mem_ifu_rdata,
    output IFU_IDU_valid, IFU_IDU_inst, IFU_IDU_pc,
    input  IDU_IFU_ready,
    input  WBU_IFU_valid, WBU_IFU_npc,
    output ifu_timeout, ifu_misalign
  );

  modport slave (
    input  ifu_mem_req, ifu_mem_addr,
    output mem_ifu_rvalid, mem_ifu_rdata,
    input  IFU_IDU_valid, IFU_IDU_inst, IFU_IDU_pc,
    output IDU_IFU_ready,
    output WBU_IFU_valid, WBU_IFU_npc,
    input  ifu_timeout, ifu_misalign
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060187_ifu.sv
// ============================================================================
// Module      : ysyx_23060187_ifu
// Description : Instruction fetch unit of the multi-cycle core. It keeps one
//               instruction in flight: request a word at pc, wait for the
//               response, hand inst+pc to IDU, then wait for the write-back
//               next PC before the following fetch.
//               Optional macro IFU_MISALIGN_CHK_EN: a misaligned next PC sets
//               ifu_misalign and parks the unit in ERROR until reset. Without
//               the macro the next PC is word-aligned and no error is raised.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060187_ifu_if.master      bus
);

  localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    FETCH_REQ = 3'd0,
    WAIT_RESP = 3'd1,
    SEND_IDU  = 3'd2,
    WAIT_NPC  = 3'd3
`ifdef IFU_MISALIGN_CHK_EN
    ,
    ERROR     = 3'd4
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_r;
  logic [7:0]  timer;
  logic [7:0]  timer_inc;
  logic        timeout_r;
`ifdef IFU_MISALIGN_CHK_EN
  logic        misalign_r;
`endif

  // Saturating increment so a long wait can never wrap the timer back to zero.
  always_comb begin
    timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;
  end

  // Fetch sequencer: one request, one response, one handoff, one next PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH_REQ;
      pc        <= RESET_PC;
      inst_r    <= '0;
      timer     <= '0;
      timeout_r <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH_REQ: begin
          timer <= '0;
          state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (bus.mem_ifu_rvalid) begin
            inst_r <= bus.mem_ifu_rdata;
            state  <= SEND_IDU;
          end else begin
            timer <= timer_inc;
            // Give up on this response and re-issue the same pc; a late
            // response to the old request is then taken as the new one.
            if (timer_inc == TIMEOUT_LIM) begin
              timeout_r <= 1'b1;
              state     <= FETCH_REQ;
            end
          end
        end
        SEND_IDU: begin
          if (bus.IDU_IFU_ready) state <= WAIT_NPC;
        end
        WAIT_NPC: begin
          if (bus.WBU_IFU_valid) begin
`ifdef IFU_MISALIGN_CHK_EN
            pc <= bus.WBU_IFU_npc;
            if (bus.WBU_IFU_npc[1:0] != 2'b00) begin
              misalign_r <= 1'b1;
              state      <= ERROR;
            end else begin
              state <= FETCH_REQ;
            end
`else
            pc    <= bus.WBU_IFU_npc & ALIGN_MASK;
            state <= FETCH_REQ;
`endif
          end
        end
`ifdef IFU_MISALIGN_CHK_EN
        ERROR: state <= ERROR;
`endif
        default: state <= FETCH_REQ;
      endcase
    end
  end

  assign bus.ifu_mem_req   = (state == FETCH_REQ);
  assign bus.ifu_mem_addr  = pc;
  assign bus.IFU_IDU_valid = (state == SEND_IDU);
  assign bus.IFU_IDU_inst  = inst_r;
  assign bus.IFU_IDU_pc    = pc;
  assign bus.ifu_timeout   = timeout_r;
`ifdef IFU_MISALIGN_CHK_EN
  assign bus.ifu_misalign  = misalign_r;
`else
  assign bus.ifu_misalign  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060187_ifu.sv
// ============================================================================
// Module      : tb_ysyx_23060187_ifu
// Description : Directed self-checking bench for ysyx_23060187_ifu, built
//               with TIMEOUT_CYCLES=4. Expectations for the misaligned next
//               PC follow IFU_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060187_ifu;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ysyx_23060187_ifu_if bus ();

  ysyx_23060187_ifu #(
    .RESET_PC      (32'h8000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_ifu_rvalid = 1'b0;
    bus.mem_ifu_rdata  = 32'h0;
    bus.IDU_IFU_ready  = 1'b0;
    bus.WBU_IFU_valid  = 1'b0;
    bus.WBU_IFU_npc    = 32'h0;
    tick(); tick();
    total++; if (bus.IFU_IDU_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.IFU_IDU_valid); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_addr: got %h exp 80000000", bus.ifu_mem_addr); end
    total++; if (bus.ifu_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b exp 0", bus.ifu_timeout); end
    total++; if (bus.ifu_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b exp 0", bus.ifu_misalign); end
  endtask

  // Release reset, memory answers in cycle 2, valid expected in cycle 3.
  task automatic test_first_fetch();
    rst = 1'b1;
    total++; if (bus.ifu_mem_req !== 1'b1) begin bad++; $display("FAIL ff_req0: got %b exp 1", bus.ifu_mem_req); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL ff_addr0: got %h exp 80000000", bus.ifu_mem_addr); end
    tick(); // cycle 1
    total++; if (bus.ifu_mem_req !== 1'b0) begin bad++; $display("FAIL ff_req1: got %b exp 0", bus.ifu_mem_req); end
    tick(); // cycle 2
    bus.mem_ifu_rvalid = 1'b1;
    bus.mem_ifu_rdata  = 32'h0000_0413;
    total++; if (bus.IFU_IDU_valid !== 1'b0) begin bad++; $display("FAIL ff_valid2: got %b exp 0", bus.IFU_IDU_valid); end
    tick(); // cycle 3
    bus.mem_ifu_rvalid = 1'b0;
    bus.mem_ifu_rdata  = 32'h0;
    total++; if (bus.IFU_IDU_valid !== 1'b1) begin bad++; $display("FAIL ff_valid3: got %b exp 1", bus.IFU_IDU_valid); end
    total++; if (bus.IFU_IDU_inst !== 32'h0000_0413) begin bad++; $display("FAIL ff_inst: got %h exp 00000413", bus.IFU_IDU_inst); end
    total++; if (bus.IFU_IDU_pc !== 32'h8000_0000) begin bad++; $display("FAIL ff_pc: got %h exp 80000000", bus.IFU_IDU_pc); end
  endtask

  // Ready low for 5 cycles with stray rvalid and WBU pulses, then handshake.
  task automatic test_hold_and_npc();
    for (int i = 0; i < 5; i++) begin
      bus.mem_ifu_rvalid = (i == 1);
      bus.mem_ifu_rdata  = 32'hBAD0_BAD0;
      bus.WBU_IFU_valid  = (i == 2);
      bus.WBU_IFU_npc    = 32'h1234_5678;
      tick();
      total++; if (bus.IFU_IDU_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b exp 1", i, bus.IFU_IDU_valid); end
      total++; if (bus.IFU_IDU_inst !== 32'h0000_0413) begin bad++; $display("FAIL hold_inst[%0d]: got %h exp 00000413", i, bus.IFU_IDU_inst); end
      total++; if (bus.IFU_IDU_pc !== 32'h8000_0000) begin bad++; $display("FAIL hold_pc[%0d]: got %h exp 80000000", i, bus.IFU_IDU_pc); end
    end
    bus.mem_ifu_rvalid = 1'b0;
    bus.WBU_IFU_valid  = 1'b0;
    bus.IDU_IFU_ready  = 1'b1; // handshake in cycle 6
    tick();
    bus.IDU_IFU_ready  = 1'b0;
    total++; if (bus.IFU_IDU_valid !== 1'b0) begin bad++; $display("FAIL hs_valid: got %b exp 0", bus.IFU_IDU_valid); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL stray_wbu_pc: got %h exp 80000000", bus.ifu_mem_addr); end
    bus.WBU_IFU_valid = 1'b1;
    bus.WBU_IFU_npc   = 32'h8000_0010;
    tick();
    bus.WBU_IFU_valid = 1'b0;
    total++; if (bus.ifu_mem_req !== 1'b1) begin bad++; $display("FAIL npc_req: got %b exp 1", bus.ifu_mem_req); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0010) begin bad++; $display("FAIL npc_addr: got %h exp 80000010", bus.ifu_mem_addr); end
  endtask

  // No response: 4 empty WAIT_RESP cycles, re-issue in cycle 5, then answer.
  task automatic test_timeout();
    int n;
    tick(); // cycle 1 WAIT_RESP
    total++; if (bus.ifu_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b exp 0", bus.ifu_timeout); end
    n = 1;
    while (bus.ifu_mem_req !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    total++; if (n !== 5) begin bad++; $display("FAIL to_reissue_cycle: got %0d exp 5", n); end
    total++; if (bus.ifu_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b exp 1", bus.ifu_timeout); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0010) begin bad++; $display("FAIL to_addr: got %h exp 80000010", bus.ifu_mem_addr); end
    tick(); tick();
    bus.mem_ifu_rvalid = 1'b1;
    bus.mem_ifu_rdata  = 32'h00A0_0093;
    tick();
    bus.mem_ifu_rvalid = 1'b0;
    total++; if (bus.IFU_IDU_valid !== 1'b1) begin bad++; $display("FAIL to_late_valid: got %b exp 1", bus.IFU_IDU_valid); end
    total++; if (bus.IFU_IDU_inst !== 32'h00A0_0093) begin bad++; $display("FAIL to_late_inst: got %h exp 00a00093", bus.IFU_IDU_inst); end
    total++; if (bus.IFU_IDU_pc !== 32'h8000_0010) begin bad++; $display("FAIL to_late_pc: got %h exp 80000010", bus.IFU_IDU_pc); end
    bus.IDU_IFU_ready = 1'b1;
    tick();
    bus.IDU_IFU_ready = 1'b0;
    bus.WBU_IFU_valid = 1'b1;
    bus.WBU_IFU_npc   = 32'h8000_0020;
    tick();
    bus.WBU_IFU_valid = 1'b0;
    total++; if (bus.ifu_mem_addr !== 32'h8000_0020) begin bad++; $display("FAIL to_next_addr: got %h exp 80000020", bus.ifu_mem_addr); end
  endtask

  // Asynchronous reset while waiting for a response; rvalid during reset dropped.
  task automatic test_reset_in_wait();
    tick(); // WAIT_RESP at 8000_0020, timeout still set
    rst = 1'b0;
    #1;
    total++; if (bus.ifu_mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL ar_addr: got %h exp 80000000", bus.ifu_mem_addr); end
    total++; if (bus.ifu_timeout !== 1'b0) begin bad++; $display("FAIL ar_timeout: got %b exp 0", bus.ifu_timeout); end
    total++; if (bus.IFU_IDU_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b exp 0", bus.IFU_IDU_valid); end
    tick();
    bus.mem_ifu_rvalid = 1'b1;
    bus.mem_ifu_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_ifu_rvalid = 1'b0;
    rst = 1'b1;
    total++; if (bus.ifu_mem_req !== 1'b1) begin bad++; $display("FAIL ar_req0: got %b exp 1", bus.ifu_mem_req); end
    tick(); // cycle 1
    total++; if (bus.IFU_IDU_valid !== 1'b0) begin bad++; $display("FAIL ar_stale: got %b exp 0", bus.IFU_IDU_valid); end
    bus.mem_ifu_rvalid = 1'b1;
    bus.mem_ifu_rdata  = 32'h0000_0013;
    tick(); // cycle 2
    bus.mem_ifu_rvalid = 1'b0;
    total++; if (bus.IFU_IDU_inst !== 32'h0000_0013) begin bad++; $display("FAIL ar_inst: got %h exp 00000013", bus.IFU_IDU_inst); end
    total++; if (bus.IFU_IDU_valid !== 1'b1) begin bad++; $display("FAIL ar_valid2: got %b exp 1", bus.IFU_IDU_valid); end
  endtask

  // Misaligned next PC 8000_0006.
  task automatic test_misalign();
    bus.IDU_IFU_ready = 1'b1;
    tick();
    bus.IDU_IFU_ready = 1'b0;
    bus.WBU_IFU_valid = 1'b1;
    bus.WBU_IFU_npc   = 32'h8000_0006;
    tick();
    bus.WBU_IFU_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    total++; if (bus.ifu_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b exp 1", bus.ifu_misalign); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.ifu_mem_req !== 1'b0) begin bad++; $display("FAIL mis_noreq[%0d]: got %b exp 0", i, bus.ifu_mem_req); end
      tick();
    end
`else
    total++; if (bus.ifu_misalign !== 1'b0) begin bad++; $display("FAIL mis_flag: got %b exp 0", bus.ifu_misalign); end
    total++; if (bus.ifu_mem_req !== 1'b1) begin bad++; $display("FAIL mis_req: got %b exp 1", bus.ifu_mem_req); end
    total++; if (bus.ifu_mem_addr !== 32'h8000_0004) begin bad++; $display("FAIL mis_addr: got %h exp 80000004", bus.ifu_mem_addr); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_fetch();
    test_hold_and_npc();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
